clut_loader: RTL
================

# clut_loader

Fill engine for the GPU palette cache: accepts a palette load request (VRAM X/Y, 4bpp or 8bpp mode), fetches the palette from VRAM as 32-byte lines over a 32-bit memory read port, and writes each assembled 256-bit line into the palette cache's 16-entry line store. Sits between the texture/primitive setup logic, which issues load requests, and the VRAM memory arbiter. It keeps a one-entry tag of the last loaded palette so repeated requests complete without memory traffic.

## Interface
- No parameters; constants live in the shared package.
- i_clk  in  1  clock.
- i_nrst  in  1  asynchronous active-low reset.
- i_loadReq  in  1  load request; accepted when o_ready=1.
- i_clutX  in  6  palette X in 16-pixel units.
- i_clutY  in  9  palette Y (VRAM row).
- i_is8bpp  in  1  1 = 256 entries (16 lines); 0 = 16 entries (1 line).
- i_invalidate  in  1  VRAM write may have touched palette; drop tag.
- o_ready  out  1  idle, able to accept a request.
- o_done  out  1  one-cycle pulse when a request completes (hit or miss).
- o_memReq  out  1  line read request, held until acked.
- o_memAddr  out  15  32-byte line address = Y*64 + X.
- i_memAck  in  1  arbiter accepted request.
- i_memValid  in  1  one 32-bit data beat valid.
- i_memData  in  32  data beat.
- o_write  out  1  cache line write strobe (one cycle).
- o_writeBlockIndex  out  4  cache line index 0..15.
- o_colors  out  256  assembled line; entry n at bits [16n+15:16n].

## Operation
- States: IDLE, REQ, RECV, WRITE.
- IDLE: o_ready=1. On i_loadReq: hit if tagValid and X,Y match tag and (!i_is8bpp or tag8bpp) -> stay IDLE, pulse o_done next cycle. Otherwise latch X,Y,mode, blk=0, clear pending-invalidate flag, go REQ.
- REQ: o_memReq=1, o_memAddr = Y*64 + ((X+blk) mod 64) (X wraps within the row, Y never increments). On i_memAck -> RECV, beat=0.
- RECV: each i_memValid writes i_memData into bits [32*beat+31:32*beat], beat++. After beat 7 -> WRITE.
- WRITE: o_write=1, o_writeBlockIndex=blk, o_colors stable. Then if blk==last (0 for 4bpp, 15 for 8bpp) -> IDLE with o_done pulse; tag updated, tagValid=1 unless invalidate was seen during the load. Else blk++ -> REQ.
- i_invalidate: clears tagValid immediately; while busy also sets pending flag so completion leaves tagValid=0. Load still completes normally.
- i_loadReq while o_ready=0 is ignored (not queued).
- i_memValid outside RECV ignored; i_memAck outside REQ ignored.

## Timing
- Reset (async, i_nrst=0): state IDLE, o_ready=1, o_done=0, o_memReq=0, o_memAddr=0, o_write=0, o_writeBlockIndex=0, o_colors=0, tagValid=0, counters 0. Reset mid-load abandons it; no write issued.
- All outputs registered.
- Hit: request at cycle N -> o_done at N+1; no o_memReq, no o_write.
- Miss, zero-wait memory: accept at N; o_memReq at N+1, ack at N+1; beats N+2..N+9; o_write at N+10; o_done at N+11 (4bpp). Each extra line adds 10 cycles minimum (8bpp minimum: o_done at N+161).
- Beats may have gaps; earliest beat is the cycle after ack.
- o_memAddr/o_memReq stable from request until ack inclusive.

## Structure
- Package gpu_clut_pkg: CLUT_BEATS=8, CLUT_LINES=16, VRAM_LINES_PER_ROW=64, line address width 15, state enum typedef.
- One sub-module: clut_line_assembler (beat counter, 256-bit shift/insert register, last-beat flag).

## Test plan
- 4bpp miss X=3,Y=100: one request addr 6403, beats 0x11110000..0x77776666,0x88887777 in order -> one o_write index 0, o_colors[31:0]=0x11110000, o_done at N+11.
- Repeat same request -> o_done at N+1, no o_memReq; 8bpp request same X,Y -> full 16-line load (tag was 4bpp).
- 8bpp X=60,Y=2: addresses 188..191 then wrap to 128..139; indices 0..15 in order; then repeat 4bpp X=60,Y=2 -> hit.
- i_invalidate pulsed during line 5 of 8bpp load -> load completes all 16 writes; identical request afterward is a miss.
- Memory beats with random 0-3 cycle gaps and ack delay of 5 cycles -> same o_colors, o_memReq held until ack.
- Assert i_nrst low during RECV of line 3 -> all outputs at reset values immediately, no o_write; next request reloads from line 0.

Source files
------------

// File: rtl/gpu_clut_pkg.sv
// Shared constants and types for the GPU palette (CLUT) fill engine.
// A palette line is 32 bytes: eight 32-bit beats, sixteen 16-bit colours.
package gpu_clut_pkg;

    localparam int CLUT_BEATS         = 8;
    localparam int CLUT_LINES         = 16;
    localparam int VRAM_LINES_PER_ROW = 64;
    localparam int LINE_ADDR_W        = 15;
    localparam int CLUT_X_W           = 6;
    localparam int CLUT_Y_W           = 9;
    localparam int BLK_W              = 4;
    localparam int BEAT_IDX_W         = 3;
    localparam int BEAT_W             = 32;
    localparam int LINE_W             = CLUT_BEATS * BEAT_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_WRITE
    } clut_state_e;

    // Row-major line address; X is already reduced modulo the row width.
    function automatic logic [LINE_ADDR_W-1:0] line_addr(
        input logic [CLUT_Y_W-1:0] y,
        input logic [CLUT_X_W-1:0] x
    );
        return {y, x};
    endfunction

endpackage

// File: rtl/clut_line_assembler.sv
// Collects eight 32-bit memory beats into one 256-bit palette line.
// The line register holds its contents until the next line overwrites it.
module clut_line_assembler
    import gpu_clut_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [BEAT_W-1:0] i_data,
    output logic [LINE_W-1:0] o_line,
    output logic              o_last
);

    logic [BEAT_IDX_W-1:0] beat_q;
    logic [BEAT_IDX_W-1:0] beat_d;
    logic [LINE_W-1:0]     line_q;
    logic [LINE_W-1:0]     line_d;
    logic                  take;

    assign take = i_en && i_valid;

    always_comb begin
        beat_d = beat_q;
        line_d = line_q;
        if (i_clear) begin
            beat_d = '0;
        end else if (take) begin
            for (int b = 0; b < CLUT_BEATS; b++) begin
                if (beat_q == BEAT_IDX_W'(b)) begin
                    line_d[b*BEAT_W +: BEAT_W] = i_data;
                end
            end
            beat_d = beat_q + BEAT_IDX_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            beat_q <= '0;
            line_q <= '0;
        end else begin
            beat_q <= beat_d;
            line_q <= line_d;
        end
    end

    assign o_line = line_q;
    assign o_last = take && (beat_q == BEAT_IDX_W'(CLUT_BEATS - 1));

endmodule

// File: rtl/clut_loader.sv
// Palette cache fill engine: fetches 1 or 16 palette lines from VRAM and
// writes them into the line store, skipping the fetch on a tag hit.
module clut_loader
    import gpu_clut_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_loadReq,
    input  logic [CLUT_X_W-1:0]    i_clutX,
    input  logic [CLUT_Y_W-1:0]    i_clutY,
    input  logic                   i_is8bpp,
    input  logic                   i_invalidate,
    output logic                   o_ready,
    output logic                   o_done,
    output logic                   o_memReq,
    output logic [LINE_ADDR_W-1:0] o_memAddr,
    input  logic                   i_memAck,
    input  logic                   i_memValid,
    input  logic [BEAT_W-1:0]      i_memData,
    output logic                   o_write,
    output logic [BLK_W-1:0]       o_writeBlockIndex,
    output logic [LINE_W-1:0]      o_colors
);

    clut_state_e            state_q, state_d;
    logic [CLUT_X_W-1:0]    x_q, x_d;
    logic [CLUT_Y_W-1:0]    y_q, y_d;
    logic                   mode8_q, mode8_d;
    logic [BLK_W-1:0]       blk_q, blk_d;
    logic                   pend_q, pend_d;
    logic                   tag_valid_q, tag_valid_d;
    logic [CLUT_X_W-1:0]    tag_x_q, tag_x_d;
    logic [CLUT_Y_W-1:0]    tag_y_q, tag_y_d;
    logic                   tag8_q, tag8_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   req_q, req_d;
    logic                   write_q, write_d;
    logic [LINE_ADDR_W-1:0] addr_q, addr_d;
    logic                   hit;
    logic                   last_blk;
    logic                   asm_last;
    logic [LINE_W-1:0]      asm_line;

    // An 8bpp tag also covers the 4bpp palette at the same origin.
    assign hit = tag_valid_q && !i_invalidate
              && (i_clutX == tag_x_q) && (i_clutY == tag_y_q)
              && (!i_is8bpp || tag8_q);

    assign last_blk = mode8_q ? (blk_q == BLK_W'(CLUT_LINES - 1))
                              : (blk_q == '0);

    clut_line_assembler u_asm (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_clear (state_q == S_REQ),
        .i_en    (state_q == S_RECV),
        .i_valid (i_memValid),
        .i_data  (i_memData),
        .o_line  (asm_line),
        .o_last  (asm_last)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        mode8_d     = mode8_q;
        blk_d       = blk_q;
        pend_d      = pend_q;
        tag_valid_d = tag_valid_q;
        tag_x_d     = tag_x_q;
        tag_y_d     = tag_y_q;
        tag8_d      = tag8_q;
        addr_d      = addr_q;
        done_d      = 1'b0;

        // An in-flight load may be reading stale VRAM; keep it untagged.
        if (i_invalidate) begin
            tag_valid_d = 1'b0;
            if (state_q != S_IDLE) pend_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_loadReq) begin
                    if (hit) begin
                        done_d = 1'b1;
                    end else begin
                        x_d     = i_clutX;
                        y_d     = i_clutY;
                        mode8_d = i_is8bpp;
                        blk_d   = '0;
                        pend_d  = 1'b0;
                        addr_d  = line_addr(i_clutY, i_clutX);
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (i_memAck) state_d = S_RECV;
            end
            S_RECV: begin
                if (asm_last) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (last_blk) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    tag_x_d     = x_q;
                    tag_y_d     = y_q;
                    tag8_d      = mode8_q;
                    tag_valid_d = !pend_q && !i_invalidate;
                end else begin
                    blk_d   = blk_q + BLK_W'(1);
                    addr_d  = line_addr(y_q, x_q + CLUT_X_W'(blk_q) + CLUT_X_W'(1));
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        req_d   = (state_d == S_REQ);
        write_d = (state_d == S_WRITE);
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            mode8_q     <= 1'b0;
            blk_q       <= '0;
            pend_q      <= 1'b0;
            tag_valid_q <= 1'b0;
            tag_x_q     <= '0;
            tag_y_q     <= '0;
            tag8_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            req_q       <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            mode8_q     <= mode8_d;
            blk_q       <= blk_d;
            pend_q      <= pend_d;
            tag_valid_q <= tag_valid_d;
            tag_x_q     <= tag_x_d;
            tag_y_q     <= tag_y_d;
            tag8_q      <= tag8_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            req_q       <= req_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
        end
    end

    assign o_ready           = ready_q;
    assign o_done            = done_q;
    assign o_memReq          = req_q;
    assign o_memAddr         = addr_q;
    assign o_write           = write_q;
    assign o_writeBlockIndex = blk_q;
    assign o_colors          = asm_line;

endmodule
